// File: rtl/paddle_control.sv
// Paddle position controller: conditions four raw pushbuttons and moves each
// paddle vertically once per frame, clamped to the visible area.

module paddle_button_conditioner #(
    parameter int DEBOUNCE = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb
);
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic             sync_meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    // Any disagreement with deb must persist for DEBOUNCE cycles before it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            deb       <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;
            if (sync == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module paddle_axis #(
    parameter int SCREEN_H = 480,
    parameter int PADDLE_H = 64,
    parameter int SPEED    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       up,
    input  logic       down,
    output logic [9:0] y
);
    localparam logic [10:0] YMAX   = 11'(SCREEN_H - PADDLE_H);
    localparam logic [10:0] STEP   = 11'(SPEED);
    localparam logic [9:0]  Y_INIT = 10'((SCREEN_H - PADDLE_H) / 2);

    typedef enum logic [1:0] {
        MOVE_HOLD,
        MOVE_UP,
        MOVE_DOWN
    } move_e;

    move_e       move;
    logic [10:0] y_wide;
    logic [10:0] down_sum;
    logic [9:0]  y_next;

    // Saturating step in 11 bits so neither end can wrap.
    always_comb begin
        move     = MOVE_HOLD;
        y_wide   = {1'b0, y};
        down_sum = y_wide + STEP;
        y_next   = y;
        if (up && !down) begin
            move = MOVE_UP;
        end else if (down && !up) begin
            move = MOVE_DOWN;
        end
        case (move)
            MOVE_UP:   y_next = (y_wide < STEP) ? 10'd0 : (y - STEP[9:0]);
            MOVE_DOWN: y_next = (down_sum > YMAX) ? YMAX[9:0] : down_sum[9:0];
            default:   y_next = y;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= Y_INIT;
        end else if (tick) begin
            y <= y_next;
        end
    end
endmodule

module paddle_control #(
    parameter int SCREEN_H = 480,
    parameter int PADDLE_H = 64,
    parameter int SPEED    = 4,
    parameter int P1_X     = 16,
    parameter int P2_X     = 616,
    parameter int DEBOUNCE = 250000
) (
    input  logic       clk50M,
    input  logic       reset_n,
    input  logic       endofframe,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    output logic [9:0] paddle_one_x,
    output logic [9:0] paddle_one_y,
    output logic [9:0] paddle_two_x,
    output logic [9:0] paddle_two_y
);
    logic eof_d;
    logic tick;
    logic p1_up_deb;
    logic p1_down_deb;
    logic p2_up_deb;
    logic p2_down_deb;

    assign paddle_one_x = 10'(P1_X);
    assign paddle_two_x = 10'(P2_X);

    // One tick per frame on the rising edge of the blanking level.
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            eof_d <= 1'b0;
        end else begin
            eof_d <= endofframe;
        end
    end

    assign tick = endofframe & ~eof_d;

    paddle_button_conditioner #(.DEBOUNCE(DEBOUNCE)) u_p1_up (
        .clk(clk50M), .rst_n(reset_n), .raw(p1_up), .deb(p1_up_deb)
    );
    paddle_button_conditioner #(.DEBOUNCE(DEBOUNCE)) u_p1_down (
        .clk(clk50M), .rst_n(reset_n), .raw(p1_down), .deb(p1_down_deb)
    );
    paddle_button_conditioner #(.DEBOUNCE(DEBOUNCE)) u_p2_up (
        .clk(clk50M), .rst_n(reset_n), .raw(p2_up), .deb(p2_up_deb)
    );
    paddle_button_conditioner #(.DEBOUNCE(DEBOUNCE)) u_p2_down (
        .clk(clk50M), .rst_n(reset_n), .raw(p2_down), .deb(p2_down_deb)
    );

    paddle_axis #(.SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H), .SPEED(SPEED)) u_axis_one (
        .clk(clk50M), .rst_n(reset_n), .tick(tick),
        .up(p1_up_deb), .down(p1_down_deb), .y(paddle_one_y)
    );
    paddle_axis #(.SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H), .SPEED(SPEED)) u_axis_two (
        .clk(clk50M), .rst_n(reset_n), .tick(tick),
        .up(p2_up_deb), .down(p2_down_deb), .y(paddle_two_y)
    );
endmodule

// File: tb/tb_paddle_control.sv
// Testbench for paddle_control: directed and random button/frame sequences
// checked against a clamped-arithmetic position model.

module tb_paddle_control;
    localparam int DEB   = 4;
    localparam int SPEED = 4;

    logic       clk50M = 1'b0;
    logic       reset_n = 1'b1;
    logic       endofframe = 1'b0;
    logic       p1_up = 1'b0;
    logic       p1_down = 1'b0;
    logic       p2_up = 1'b0;
    logic       p2_down = 1'b0;
    logic [9:0] a_one_x, a_one_y, a_two_x, a_two_y;
    logic [9:0] b_one_x, b_one_y, b_two_x, b_two_y;

    int n_checks = 0;
    int n_fail   = 0;

    // Lanes: 0/1 = default DUT paddle one/two, 2/3 = odd-height DUT paddle one/two.
    int  exp_y [4];
    int  ymax  [4] = '{416, 416, 422, 422};
    int  yinit [4] = '{208, 208, 211, 211};
    bit  deb_up [4];
    bit  deb_dn [4];

    paddle_control #(.DEBOUNCE(DEB)) u_dut (
        .clk50M(clk50M), .reset_n(reset_n), .endofframe(endofframe),
        .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
        .paddle_one_x(a_one_x), .paddle_one_y(a_one_y),
        .paddle_two_x(a_two_x), .paddle_two_y(a_two_y)
    );

    paddle_control #(.SCREEN_H(486), .DEBOUNCE(DEB)) u_dut_odd (
        .clk50M(clk50M), .reset_n(reset_n), .endofframe(endofframe),
        .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
        .paddle_one_x(b_one_x), .paddle_one_y(b_one_y),
        .paddle_two_x(b_two_x), .paddle_two_y(b_two_y)
    );

    always #5 clk50M = ~clk50M;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int model_move(int y, bit up, bit dn, int lim);
        if (up && !dn) return (y - SPEED < 0) ? 0 : y - SPEED;
        if (dn && !up) return (y + SPEED > lim) ? lim : y + SPEED;
        return y;
    endfunction

    function automatic logic [9:0] lane_y(int lane);
        case (lane)
            0:       return a_one_y;
            1:       return a_two_y;
            2:       return b_one_y;
            default: return b_two_y;
        endcase
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk50M);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        assert (act === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        for (int l = 0; l < 4; l++)
            checkOutput($sformatf("%s_lane%0d", tag, l), lane_y(l), 10'(exp_y[l]));
    endtask

    // Drive raw buttons and hold them long enough to be accepted.
    task automatic applyStimulus(input bit u1, input bit d1, input bit u2, input bit d2);
        p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2;
        step(DEB + 4);
        for (int l = 0; l < 4; l++) begin
            deb_up[l] = (l % 2 == 0) ? u1 : u2;
            deb_dn[l] = (l % 2 == 0) ? d1 : d2;
        end
    endtask

    task automatic modelTick();
        for (int l = 0; l < 4; l++)
            exp_y[l] = model_move(exp_y[l], deb_up[l], deb_dn[l], ymax[l]);
    endtask

    task automatic frame();
        endofframe = 1'b1;
        step(1);
        modelTick();
        endofframe = 1'b0;
        step(1);
    endtask

    task automatic doReset();
        p1_up = 0; p1_down = 0; p2_up = 0; p2_down = 0; endofframe = 0;
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
        for (int l = 0; l < 4; l++) begin
            exp_y[l] = yinit[l];
            deb_up[l] = 0;
            deb_dn[l] = 0;
        end
    endtask

    initial begin
        logic [31:0] r;

        // Reset state and idle frames
        doReset();
        checkOutput("rst_x1", a_one_x, 10'd16);
        checkOutput("rst_x2", a_two_x, 10'd616);
        checkOutput("rst_y1", a_one_y, 10'd208);
        checkOutput("rst_y2", a_two_y, 10'd208);
        checkAll("rst");
        repeat (3) frame();
        checkAll("idle");

        // Paddle one up for 10 frames
        applyStimulus(1, 0, 0, 0);
        repeat (10) frame();
        checkOutput("up10_y1", a_one_y, 10'd168);
        checkOutput("up10_y2", a_two_y, 10'd208);
        checkAll("up10");

        // Paddle two down saturation, then up to zero without wrap
        applyStimulus(0, 0, 0, 1);
        for (int f = 0; f < 60; f++) begin
            frame();
            checkOutput("sat_dn", a_two_y, 10'(exp_y[1]));
        end
        checkOutput("sat_max", a_two_y, 10'd416);
        checkOutput("sat_max_odd", b_two_y, 10'd422);
        applyStimulus(0, 0, 1, 0);
        for (int f = 0; f < 110; f++) begin
            frame();
            checkOutput("sat_up_odd", b_two_y, 10'(exp_y[3]));
        end
        checkOutput("sat_zero", a_two_y, 10'd0);
        checkOutput("sat_zero_odd", b_two_y, 10'd0);
        applyStimulus(0, 0, 0, 0);

        // Glitch rejection and debounce latency
        doReset();
        p1_up = 1'b1;
        step(3);
        p1_up = 1'b0;
        step(8);
        frame();
        checkOutput("glitch", a_one_y, 10'd208);
        p1_up = 1'b1;
        step(5);
        endofframe = 1'b1;
        step(1);
        endofframe = 1'b0;
        checkOutput("deb_early", a_one_y, 10'd208);
        step(1);
        p1_up = 1'b0;
        step(10);
        p1_up = 1'b1;
        step(6);
        endofframe = 1'b1;
        step(1);
        endofframe = 1'b0;
        checkOutput("deb_ontime", a_one_y, 10'd204);
        checkOutput("deb_ontime_odd", b_one_y, 10'd207);
        p1_up = 1'b0;
        step(10);

        // Long endofframe level gives a single move; both buttons hold
        doReset();
        applyStimulus(0, 1, 0, 0);
        endofframe = 1'b1;
        step(100);
        modelTick();
        endofframe = 1'b0;
        step(1);
        checkOutput("long_eof", a_one_y, 10'd212);
        checkAll("long_eof");
        applyStimulus(1, 1, 0, 0);
        frame();
        checkOutput("both_held", a_one_y, 10'd212);

        // Random button combinations
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            applyStimulus(r[0], r[1], r[2], r[3]);
            repeat (int'(r[5:4]) + 1) frame();
            checkAll("rand");
        end

        // Asynchronous reset mid-frame
        doReset();
        applyStimulus(0, 1, 0, 0);
        repeat (23) frame();
        checkOutput("pre_rst", a_one_y, 10'd300);
        applyStimulus(0, 0, 0, 0);
        @(posedge clk50M);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_y1", a_one_y, 10'd208);
        checkOutput("async_y1_odd", b_one_y, 10'd211);
        step(2);
        reset_n = 1'b1;
        step(2);
        checkOutput("post_rst", a_one_y, 10'd208);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
